ps2_input_port: RTL and testbench

PS2_INPUT_PORT -- requirements
Module: ps2_input_port

---
 rtl/ps2_input_port.sv | 171 +++++++++++++++++
 tb/tb_ps2_input_port.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_input_port.sv
// PS/2 keyboard receiver feeding a memory-mapped input port.
// Synchronises the raw PS/2 pins, deframes 11-bit frames, queues received
// bytes in a 4-deep FIFO and presents a registered status/data word.
module ps2_input_port #(
   parameter logic [23:0] KBD_ADDR       = 24'h7FFF00,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   input  logic        rd_strobe,
   input  logic        clr_err,
   output logic [23:0] input_addr,
   output logic [15:0] input_data
);

   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   // synchronisers and edge detection
   logic r_ck_s0, r_ck_s1, r_ck_s2;
   logic r_dt_s0, r_dt_s1, r_dt_s2;
   logic r_edge;

   // receive path
   state_t            r_state, w_state_nxt;
   logic [2:0]        r_bitcnt;
   logic [7:0]        r_shift;
   logic              r_par;
   logic [WD_W-1:0]   r_wdog;
   logic              r_push;
   logic              w_shift_en, w_cap_par, w_stop_edge, w_timeout, w_par_ok;

   // FIFO and flags
   logic [7:0]        r_mem [0:3];
   logic [1:0]        r_wp, r_rp;
   logic [2:0]        r_cnt;
   logic              r_ovf, r_perr, r_ferr;
   logic              w_pop, w_push_ok;
   logic              w_set_ovf, w_set_perr, w_set_ferr;
   logic [7:0]        w_head;

   assign input_addr = KBD_ADDR;

   // Two-flop synchronisers plus one extra stage so a registered falling-edge
   // pulse lines up with the data sample taken on the same pin transition.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_ck_s0 <= 1'b1;
         r_ck_s1 <= 1'b1;
         r_ck_s2 <= 1'b1;
         r_dt_s0 <= 1'b1;
         r_dt_s1 <= 1'b1;
         r_dt_s2 <= 1'b1;
         r_edge  <= 1'b0;
      end else begin
         r_ck_s0 <= ps2_clk;
         r_ck_s1 <= r_ck_s0;
         r_ck_s2 <= r_ck_s1;
         r_dt_s0 <= ps2_data;
         r_dt_s1 <= r_dt_s0;
         r_dt_s2 <= r_dt_s1;
         r_edge  <= r_ck_s2 & ~r_ck_s1;
      end
   end

   assign w_timeout = (r_state != IDLE) && (r_wdog == WD_W'(TIMEOUT_CYCLES));
   assign w_par_ok  = ^{r_shift, r_par};

   // Receive FSM state register.
   always_ff @(posedge clk) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Receive FSM next state and per-edge actions; watchdog abort overrides.
   always_comb begin
      w_state_nxt = r_state;
      w_shift_en  = 1'b0;
      w_cap_par   = 1'b0;
      w_stop_edge = 1'b0;
      if (w_timeout) begin
         w_state_nxt = IDLE;
      end else if (r_edge) begin
         unique case (r_state)
            IDLE:    if (!r_dt_s2) w_state_nxt = DATA;
            DATA: begin
               w_shift_en = 1'b1;
               if (r_bitcnt == 3'd7) w_state_nxt = PARITY;
            end
            PARITY: begin
               w_cap_par   = 1'b1;
               w_state_nxt = STOP;
            end
            STOP: begin
               w_stop_edge = 1'b1;
               w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // Bit counter, shift register, parity capture, watchdog and push request.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_bitcnt <= '0;
         r_shift  <= '0;
         r_par    <= 1'b0;
         r_wdog   <= '0;
         r_push   <= 1'b0;
      end else begin
         if (w_state_nxt != DATA) r_bitcnt <= '0;
         else if (w_shift_en)     r_bitcnt <= r_bitcnt + 3'd1;
         if (w_shift_en) r_shift <= {r_dt_s2, r_shift[7:1]};
         if (w_cap_par)  r_par   <= r_dt_s2;
         if (r_edge || r_state == IDLE || w_timeout)
            r_wdog <= '0;
         else if (r_wdog != WD_W'(TIMEOUT_CYCLES))
            r_wdog <= r_wdog + WD_W'(1);
         r_push <= w_stop_edge & r_dt_s2 & w_par_ok;
      end
   end

   assign w_pop      = rd_strobe && (r_cnt != 3'd0);
   assign w_push_ok  = r_push && ((r_cnt != 3'd4) || w_pop);
   assign w_set_ovf  = r_push && (r_cnt == 3'd4) && !w_pop;
   assign w_set_perr = w_stop_edge && !w_par_ok;
   assign w_set_ferr = (w_stop_edge && !r_dt_s2) || w_timeout;
   assign w_head     = (r_cnt != 3'd0) ? r_mem[r_rp] : 8'h00;

   // FIFO storage; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wp] <= r_shift;
   end

   // FIFO pointers, occupancy and sticky error flags (a set beats clr_err).
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wp   <= '0;
         r_rp   <= '0;
         r_cnt  <= '0;
         r_ovf  <= 1'b0;
         r_perr <= 1'b0;
         r_ferr <= 1'b0;
      end else begin
         if (w_push_ok) r_wp <= r_wp + 2'd1;
         if (w_pop)     r_rp <= r_rp + 2'd1;
         unique case ({w_push_ok, w_pop})
            2'b10:   r_cnt <= r_cnt + 3'd1;
            2'b01:   r_cnt <= r_cnt - 3'd1;
            default: r_cnt <= r_cnt;
         endcase
         r_ovf  <= w_set_ovf  | (r_ovf  & ~clr_err);
         r_perr <= w_set_perr | (r_perr & ~clr_err);
         r_ferr <= w_set_ferr | (r_ferr & ~clr_err);
      end
   end

   // Registered status/data word seen by the memory controller.
   always_ff @(posedge clk) begin
      if (!reset) begin
         input_data <= '0;
      end else begin
         input_data <= {(r_cnt != 3'd0), r_ovf, r_perr, r_ferr, 1'b0, r_cnt, w_head};
      end
   end

endmodule

// File: tb/tb_ps2_input_port.sv
// Scoreboard bench for ps2_input_port: a queue-based FIFO/flag model predicts
// every change of input_data; a monitor compares each observed change.
module tb_ps2_input_port;

   localparam int unsigned TO = 200;
   localparam int unsigned H  = 20;
   localparam logic [23:0] ADDR = 24'h7FFF00;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic        rd_strobe = 1'b0;
   logic        clr_err = 1'b0;
   logic [23:0] input_addr;
   logic [15:0] input_data;

   always #5 clk = ~clk;

   ps2_input_port #(.KBD_ADDR(ADDR), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .rd_strobe(rd_strobe), .clr_err(clr_err),
      .input_addr(input_addr), .input_data(input_data)
   );

   typedef struct {
      int          kind;   // 0 word check, 1 address check, 2 bound expired
      string       name;
      logic [15:0] exp;
   } chk_t;

   logic [7:0]  mq[$];
   bit          m_ovf = 0, m_perr = 0, m_ferr = 0;
   logic [15:0] last_exp = 16'h0000;
   logic [15:0] exp_q[$];
   chk_t        chk_q[$];
   int          vectors = 0, miscompares = 0;
   bit          mon_en = 0;
   logic [15:0] last_seen = 16'h0000;

   function automatic logic [15:0] model_word();
      logic [2:0] c;
      logic [7:0] h;
      c = 3'(mq.size());
      h = (mq.size() != 0) ? mq[0] : 8'h00;
      return {(mq.size() != 0), m_ovf, m_perr, m_ferr, 1'b0, c, h};
   endfunction

   task automatic model_emit();
      logic [15:0] w;
      w = model_word();
      if (w !== last_exp) begin
         exp_q.push_back(w);
         last_exp = w;
      end
   endtask

   // Monitor: direct checks and scoreboard comparison on every output change.
   always @(negedge clk) begin
      while (chk_q.size() != 0) begin
         chk_t c;
         c = chk_q.pop_front();
         vectors++;
         if (c.kind == 0 && input_data !== c.exp) begin
            miscompares++;
            $display("FAIL %s: input_data=%h required=%h", c.name, input_data, c.exp);
         end else if (c.kind == 1 && input_addr !== ADDR) begin
            miscompares++;
            $display("FAIL %s: input_addr=%h required=%h", c.name, input_addr, ADDR);
         end else if (c.kind == 2) begin
            miscompares++;
            $display("FAIL %s: %0d expected words never appeared, required 0", c.name, c.exp);
         end
      end
      if (mon_en && input_data !== last_seen) begin
         last_seen = input_data;
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_change: input_data=%h required no change", input_data);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            if (input_data !== e) begin
               miscompares++;
               $display("FAIL scoreboard: input_data=%h required=%h", input_data, e);
            end
         end
      end
   end

   task automatic check_word(input string name, input logic [15:0] exp);
      chk_q.push_back('{0, name, exp});
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         chk_q.push_back('{2, "drain_timeout", 16'(exp_q.size())});
         exp_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic send_bit(input logic b, input bit pop);
      @(negedge clk);
      ps2_data = b;
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      if (pop) begin
         repeat (4) @(negedge clk);
         rd_strobe = 1'b1;
         @(negedge clk);
         rd_strobe = 1'b0;
         repeat (H - 5) @(negedge clk);
      end else begin
         repeat (H) @(negedge clk);
      end
      ps2_clk = 1'b1;
   endtask

   task automatic send_bits(input logic [10:0] bits, input int unsigned lo, input int unsigned hi);
      for (int unsigned i = lo; i < hi; i++) send_bit(bits[i], 1'b0);
   endtask

   task automatic frame(input logic [7:0] b, input logic par, input logic stop, input bit pop);
      logic [10:0] bits;
      bit good_par;
      bits = {stop, par, b, 1'b0};
      send_bits(bits, 0, 10);
      good_par = ^{b, par};
      if (!good_par) m_perr = 1;
      if (!stop)     m_ferr = 1;
      model_emit();
      if (pop && mq.size() != 0) void'(mq.pop_front());
      if (good_par && stop) begin
         if (mq.size() < 4) mq.push_back(b);
         else               m_ovf = 1;
      end
      model_emit();
      send_bit(stop, pop);
      @(negedge clk);
      ps2_data = 1'b1;
      repeat (10) @(negedge clk);
      wait_drain();
   endtask

   task automatic good_frame(input logic [7:0] b, input bit pop);
      frame(b, ~^b, 1'b1, pop);
   endtask

   task automatic do_pop();
      @(negedge clk);
      rd_strobe = 1'b1;
      if (mq.size() != 0) void'(mq.pop_front());
      model_emit();
      @(negedge clk);
      rd_strobe = 1'b0;
      wait_drain();
   endtask

   task automatic do_clr();
      @(negedge clk);
      clr_err = 1'b1;
      m_ovf = 0; m_perr = 0; m_ferr = 0;
      model_emit();
      @(negedge clk);
      clr_err = 1'b0;
      wait_drain();
   endtask

   task automatic flush();
      while (mq.size() != 0) do_pop();
      do_clr();
   endtask

   initial begin
      #2ms;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1, "global timeout");
   end

   initial begin
      logic [10:0] bits;
      repeat (5) @(negedge clk);
      chk_q.push_back('{0, "reset_state", 16'h0000});
      chk_q.push_back('{1, "addr_const", 16'h0000});
      @(negedge clk);
      reset = 1'b1;
      mon_en = 1;
      repeat (5) @(negedge clk);

      // single good frame, then pop
      good_frame(8'h1C, 0);
      check_word("frame_1c", 16'h811C);
      do_pop();
      check_word("pop_empty", 16'h0000);

      // parity error, then clear
      frame(8'h1C, 1'b1, 1'b1, 0);
      check_word("parity_err", 16'h2000);
      do_clr();
      check_word("clr_err", 16'h0000);

      // overflow on fifth frame, then drain
      for (int i = 1; i <= 5; i++) good_frame(8'(i), 0);
      check_word("overflow_full", 16'hC401);
      do_pop(); check_word("pop_head2", 16'hC302);
      do_pop(); check_word("pop_head3", 16'hC203);
      do_pop(); check_word("pop_head4", 16'hC104);
      do_pop(); check_word("pop_last", 16'h4000);
      do_clr();

      // push coincident with pop while full
      for (int i = 1; i <= 4; i++) good_frame(8'(i), 0);
      check_word("full_no_ovf", 16'h8401);
      good_frame(8'h06, 1);
      check_word("push_pop_full", 16'h8402);
      do_pop(); do_pop(); do_pop();
      check_word("fourth_entry", 16'h8106);
      do_pop();
      check_word("drained", 16'h0000);

      // coincident push and pop on an empty FIFO
      good_frame(8'h33, 1);
      check_word("push_pop_empty", 16'h8133);
      flush();

      // watchdog abort of a partial frame
      bits = {1'b1, 1'b1, 8'hA5, 1'b0};
      send_bits(bits, 0, 5);
      m_ferr = 1;
      model_emit();
      repeat (TO + 10) @(negedge clk);
      wait_drain();
      check_word("timeout", 16'h1000);
      good_frame(8'h5A, 0);
      check_word("after_timeout", 16'h915A);
      flush();

      // reset in the middle of a frame
      good_frame(8'h11, 0);
      bits = {1'b1, 1'b1, 8'hFF, 1'b0};
      send_bits(bits, 0, 4);
      @(negedge clk);
      reset = 1'b0;
      mq.delete();
      m_ovf = 0; m_perr = 0; m_ferr = 0;
      model_emit();
      repeat (4) @(negedge clk);
      reset = 1'b1;
      send_bits(bits, 4, 11);
      repeat (10) @(negedge clk);
      wait_drain();
      check_word("reset_midframe", 16'h0000);
      good_frame(8'h29, 0);
      check_word("after_reset", 16'h8129);
      flush();

      // randomized traffic
      for (int n = 0; n < 40; n++) begin
         int unsigned op;
         logic [7:0]  b;
         op = $urandom_range(0, 9);
         b  = 8'($urandom);
         if (op <= 5) begin
            frame(b, ($urandom_range(0, 99) < 15) ? ^b : ~^b,
                  ($urandom_range(0, 99) < 10) ? 1'b0 : 1'b1,
                  $urandom_range(0, 99) < 15);
         end else if (op <= 7 || op == 9) begin
            do_pop();
         end else begin
            do_clr();
         end
      end
      check_word("random_final", model_word());

      wait_drain();
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
